ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus execute-side operand forwarding that directly feeds the ALU
//  (portA, portB, aluop). Latches decoded operands, applies EX/MEM and MEM/WB forwarding,
//  selects the immediate/shift source, and detects load-use hazards (stall + bubble).
//  Sits between decode and alu in each core of the dual-core pipeline.
// PARAMETERS
//  WORD_W   32  datapath width (must match word_t)
//  REG_AW   5   register-address width
// PORTS
//  CLK            in   1       clock, all state updates on rising edge
//  nRST           in   1       reset, synchronous, active-low
//  en             in   1       pipeline advance (low = memory stall, freeze stage)
//  flush          in   1       squash stage contents (branch/jump resolved)
//  valid_in       in   1       decode slot holds a real instruction
//  rdat1_in       in   WORD_W  rs register-file data
//  rdat2_in       in   WORD_W  rt register-file data
//  rs_in, rt_in   in   REG_AW  source register numbers
//  wsel_in        in   REG_AW  destination register number
//  imm16_in       in   16      instruction immediate
//  shamt_in       in   5       shift amount
//  alusrc_in      in   2       B source: 00 rt, 01 sign-ext imm, 10 zero-ext imm, 11 {imm16,16'h0}
//  shift_in       in   1       A source = zero-extended shamt
//  uses_rs_in     in   1       instruction reads rs
//  uses_rt_in     in   1       instruction reads rt
//  aluop_in       in   4       aluop_t for this instruction
//  regwrite_in    in   1       instruction writes register file
//  memread_in     in   1       instruction is a load
//  memwrite_in    in   1       instruction is a store
//  exmem_regwrite in   1       EX/MEM stage writes a register
//  exmem_wsel     in   REG_AW  EX/MEM destination
//  exmem_data     in   WORD_W  EX/MEM ALU result
//  memwb_regwrite in   1       MEM/WB stage writes a register
//  memwb_wsel     in   REG_AW  MEM/WB destination
//  memwb_wdat     in   WORD_W  MEM/WB writeback data
//  portA, portB   out  WORD_W  ALU operands (combinational from stage regs + forwarding)
//  aluop          out  4       ALU operation (registered)
//  store_data     out  WORD_W  forwarded rt value for stores
//  valid_out, wsel_out, regwrite_out, memread_out, memwrite_out  out  registered pass-through
//  stall_req      out  1       load-use hazard: decode/fetch must hold
// BEHAVIOUR
//  Stage update priority per rising CLK:
//   1. !nRST: all regs 0 (aluop=4'h0 ALU_SLL, valid/ctrl 0) -> bubble = sll $0,$0,0.
//   2. flush: load bubble regardless of en.
//   3. !en: hold every register.
//   4. stall_req: load bubble; decode holds its instruction (re-presented next cycle).
//   5. else capture all *_in fields.
//  Bubble: valid, regwrite, memread, memwrite = 0; wsel = 0; aluop = 0; data regs 0.
//  stall_req (comb) = valid_out & memread_out & (wsel_out!=0) &
//   ((uses_rs_in & rs_in==wsel_out) | (uses_rt_in & rt_in==wsel_out)) & valid_in.
//  Forwarding (comb, per operand, on latched rs/rt):
//   - Register 0 is never forwarded; latched value is used.
//   - EX/MEM match (exmem_regwrite & exmem_wsel==reg) beats MEM/WB match.
//   - MEM/WB match (memwb_regwrite & memwb_wsel==reg) else latched rdat.
//  portA = shift ? {27'b0,shamt} : fwdA.
//  portB per alusrc: 00 fwdB, 01 {{16{imm[15]}},imm}, 10 {16'h0,imm}, 11 {imm,16'h0}.
//  store_data = fwdB always (independent of alusrc).
//  Latency: one cycle from decode capture to ALU operands; no extra latency on forwarding.
//  Simultaneous flush + stall_req: flush wins; stall_req may still be high but is harmless.
//  Reset mid-stall: state cleared; stall_req drops because valid_out=0.
// TESTING
//  1. Reset: nRST=0 one cycle -> valid_out=0, aluop=0, portA=portB=0 (no forwarding hit), stall_req=0.
//  2. ADD r3=r1+r2, rdat1=5, rdat2=7, no hazards -> next cycle portA=5, portB=7, aluop=ADD.
//  3. rs=4, exmem_wsel=4 data=0xAA, memwb_wsel=4 wdat=0xBB -> portA=0xAA; exmem_regwrite=0 -> 0xBB.
//  4. rs=0, exmem_wsel=0, exmem_regwrite=1, data=0xFF -> portA = latched rdat1 (0).
//  5. lw r5 in stage, decode add uses r5 -> stall_req=1, next cycle bubble (valid_out=0), add captured after.
//  6. en=0 for 3 cycles with new inputs -> outputs frozen; flush=1 with en=0 -> bubble; alusrc=11, imm=0x1234 -> portB=0x12340000.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with execute-side operand forwarding and load-use hazard detection.
// Feeds portA/portB/aluop straight into the ALU one cycle after decode capture.
module ex_operand_stage #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] rdat1_in,
  input  logic [WORD_W-1:0] rdat2_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] wsel_in,
  input  logic [15:0]       imm16_in,
  input  logic [4:0]        shamt_in,
  input  logic [1:0]        alusrc_in,
  input  logic              shift_in,
  input  logic              uses_rs_in,
  input  logic              uses_rt_in,
  input  logic [3:0]        aluop_in,
  input  logic              regwrite_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_wsel,
  input  logic [WORD_W-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_wsel,
  input  logic [WORD_W-1:0] memwb_wdat,
  output logic [WORD_W-1:0] portA,
  output logic [WORD_W-1:0] portB,
  output logic [3:0]        aluop,
  output logic [WORD_W-1:0] store_data,
  output logic              valid_out,
  output logic [REG_AW-1:0] wsel_out,
  output logic              regwrite_out,
  output logic              memread_out,
  output logic              memwrite_out,
  output logic              stall_req
);

  logic              vld_p1;
  logic              regwrite_p1, memread_p1, memwrite_p1, shift_p1;
  logic [REG_AW-1:0] rs_p1, rt_p1, wsel_p1;
  logic [WORD_W-1:0] rdat1_p1, rdat2_p1;
  logic [15:0]       imm16_p1;
  logic [4:0]        shamt_p1;
  logic [1:0]        alusrc_p1;
  logic [3:0]        aluop_p1;
  logic [WORD_W-1:0] fwd_a, fwd_b;

  // Youngest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [WORD_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] r,
    input logic [WORD_W-1:0] latched,
    input logic              em_we,
    input logic [REG_AW-1:0] em_sel,
    input logic [WORD_W-1:0] em_dat,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_sel,
    input logic [WORD_W-1:0] mw_dat
  );
    if (r == '0)                   return latched;
    else if (em_we && em_sel == r) return em_dat;
    else if (mw_we && mw_sel == r) return mw_dat;
    else                           return latched;
  endfunction

  function automatic logic [WORD_W-1:0] b_sel(
    input logic [1:0]        src,
    input logic [WORD_W-1:0] reg_val,
    input logic [15:0]       imm
  );
    case (src)
      2'b00:   return reg_val;
      2'b01:   return {{(WORD_W-16){imm[15]}}, imm};
      2'b10:   return {{(WORD_W-16){1'b0}}, imm};
      default: return {imm, {(WORD_W-16){1'b0}}};
    endcase
  endfunction

  assign stall_req = vld_p1 & memread_p1 & (wsel_p1 != '0) & valid_in &
                     ((uses_rs_in & (rs_in == wsel_p1)) | (uses_rt_in & (rt_in == wsel_p1)));

  // ---- p0 -> p1: decode capture; bubble is sll $0,$0,0 with all fields cleared ----
  always_ff @(posedge CLK) begin
    if (!nRST || flush || (en && stall_req)) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      shift_p1    <= 1'b0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      wsel_p1     <= '0;
      rdat1_p1    <= '0;
      rdat2_p1    <= '0;
      imm16_p1    <= '0;
      shamt_p1    <= '0;
      alusrc_p1   <= '0;
      aluop_p1    <= '0;
    end else if (en) begin
      vld_p1      <= valid_in;
      regwrite_p1 <= regwrite_in;
      memread_p1  <= memread_in;
      memwrite_p1 <= memwrite_in;
      shift_p1    <= shift_in;
      rs_p1       <= rs_in;
      rt_p1       <= rt_in;
      wsel_p1     <= wsel_in;
      rdat1_p1    <= rdat1_in;
      rdat2_p1    <= rdat2_in;
      imm16_p1    <= imm16_in;
      shamt_p1    <= shamt_in;
      alusrc_p1   <= alusrc_in;
      aluop_p1    <= aluop_in;
    end
  end

  // ---- p1: forwarding and operand select, combinational into the ALU ----
  assign fwd_a = fwd_sel(rs_p1, rdat1_p1, exmem_regwrite, exmem_wsel, exmem_data,
                         memwb_regwrite, memwb_wsel, memwb_wdat);
  assign fwd_b = fwd_sel(rt_p1, rdat2_p1, exmem_regwrite, exmem_wsel, exmem_data,
                         memwb_regwrite, memwb_wsel, memwb_wdat);

  assign portA        = shift_p1 ? {{(WORD_W-5){1'b0}}, shamt_p1} : fwd_a;
  assign portB        = b_sel(alusrc_p1, fwd_b, imm16_p1);
  assign store_data   = fwd_b;
  assign aluop        = aluop_p1;
  assign valid_out    = vld_p1;
  assign wsel_out     = wsel_p1;
  assign regwrite_out = regwrite_p1;
  assign memread_out  = memread_p1;
  assign memwrite_out = memwrite_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        nRST, en, flush, valid_in;
  logic [31:0] rdat1_in, rdat2_in;
  logic [4:0]  rs_in, rt_in, wsel_in, shamt_in;
  logic [15:0] imm16_in;
  logic [1:0]  alusrc_in;
  logic        shift_in, uses_rs_in, uses_rt_in;
  logic [3:0]  aluop_in;
  logic        regwrite_in, memread_in, memwrite_in;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_wsel, memwb_wsel;
  logic [31:0] exmem_data, memwb_wdat;
  logic [31:0] portA, portB, store_data;
  logic [3:0]  aluop;
  logic        valid_out, regwrite_out, memread_out, memwrite_out, stall_req;
  logic [4:0]  wsel_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  ex_operand_stage #(.WORD_W(32), .REG_AW(5)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .valid_in(valid_in),
    .rdat1_in(rdat1_in), .rdat2_in(rdat2_in), .rs_in(rs_in), .rt_in(rt_in),
    .wsel_in(wsel_in), .imm16_in(imm16_in), .shamt_in(shamt_in),
    .alusrc_in(alusrc_in), .shift_in(shift_in), .uses_rs_in(uses_rs_in),
    .uses_rt_in(uses_rt_in), .aluop_in(aluop_in), .regwrite_in(regwrite_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .exmem_regwrite(exmem_regwrite), .exmem_wsel(exmem_wsel), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
    .portA(portA), .portB(portB), .aluop(aluop), .store_data(store_data),
    .valid_out(valid_out), .wsel_out(wsel_out), .regwrite_out(regwrite_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out), .stall_req(stall_req)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wsel,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op,
                        input logic mrd);
    valid_in = 1'b1; rs_in = rs; rt_in = rt; wsel_in = wsel;
    rdat1_in = d1; rdat2_in = d2; aluop_in = op; memread_in = mrd;
    regwrite_in = 1'b1; uses_rs_in = 1'b1; uses_rt_in = 1'b1;
    alusrc_in = 2'b00; shift_in = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; en = 1'b1; flush = 1'b0; valid_in = 1'b0;
    rdat1_in = '0; rdat2_in = '0; rs_in = '0; rt_in = '0; wsel_in = '0;
    imm16_in = '0; shamt_in = '0; alusrc_in = '0; shift_in = 1'b0;
    uses_rs_in = 1'b0; uses_rt_in = 1'b0; aluop_in = '0;
    regwrite_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
    exmem_regwrite = 1'b0; exmem_wsel = '0; exmem_data = '0;
    memwb_regwrite = 1'b0; memwb_wsel = '0; memwb_wdat = '0;

    // reset
    step();
    chk("rst_valid", valid_out, 0);
    chk("rst_aluop", aluop, 0);
    chk("rst_portA", portA, 0);
    chk("rst_portB", portB, 0);
    chk("rst_stall", stall_req, 0);
    nRST = 1'b1;

    // ADD r3 = r1 + r2
    decode(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 4'h2, 1'b0);
    step();
    chk("add_portA", portA, 32'd5);
    chk("add_portB", portB, 32'd7);
    chk("add_aluop", aluop, 4'h2);
    chk("add_valid", valid_out, 1);
    chk("add_wsel", wsel_out, 5'd3);
    chk("add_store", store_data, 32'd7);

    // forwarding priority on rs=4
    decode(5'd4, 5'd2, 5'd3, 32'h11, 32'd7, 4'h2, 1'b0);
    step();
    exmem_regwrite = 1'b1; exmem_wsel = 5'd4; exmem_data = 32'hAA;
    memwb_regwrite = 1'b1; memwb_wsel = 5'd4; memwb_wdat = 32'hBB;
    #1 chk("fwd_exmem", portA, 32'hAA);
    chk("fwd_b_nohit", portB, 32'd7);
    exmem_regwrite = 1'b0;
    #1 chk("fwd_memwb", portA, 32'hBB);
    memwb_regwrite = 1'b0;
    #1 chk("fwd_none", portA, 32'h11);

    // register 0 is never forwarded
    decode(5'd0, 5'd2, 5'd3, 32'h33, 32'd7, 4'h2, 1'b0);
    step();
    exmem_regwrite = 1'b1; exmem_wsel = 5'd0; exmem_data = 32'hFF;
    #1 chk("r0_nofwd", portA, 32'h33);
    exmem_regwrite = 1'b0;

    // load-use: lw r5 in stage, add r6 = r5 + r2 in decode
    decode(5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 4'h2, 1'b1);
    step();
    decode(5'd5, 5'd2, 5'd6, 32'h50, 32'h9, 4'h2, 1'b0);
    #1 chk("lu_stall", stall_req, 1);
    uses_rs_in = 1'b0;
    #1 chk("lu_no_use", stall_req, 0);
    uses_rs_in = 1'b1;
    #1;
    step();
    chk("lu_bubble_vld", valid_out, 0);
    chk("lu_bubble_op", aluop, 0);
    chk("lu_stall_drop", stall_req, 0);
    step();
    chk("lu_add_vld", valid_out, 1);
    chk("lu_add_wsel", wsel_out, 5'd6);
    memwb_regwrite = 1'b1; memwb_wsel = 5'd5; memwb_wdat = 32'h77;
    #1 chk("lu_add_fwd", portA, 32'h77);
    memwb_regwrite = 1'b0;

    // reset while stalling
    decode(5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 4'h2, 1'b1);
    step();
    decode(5'd5, 5'd2, 5'd6, 32'h50, 32'h9, 4'h2, 1'b0);
    #1 chk("rs_stall_pre", stall_req, 1);
    nRST = 1'b0;
    step();
    chk("rs_stall_vld", valid_out, 0);
    chk("rs_stall_req", stall_req, 0);
    nRST = 1'b1;

    // freeze with en low, then flush during freeze
    decode(5'd1, 5'd2, 5'd7, 32'h21, 32'h22, 4'h3, 1'b0);
    step();
    en = 1'b0;
    decode(5'd8, 5'd9, 5'd9, 32'h99, 32'h22, 4'h5, 1'b0);
    alusrc_in = 2'b11; imm16_in = 16'h1234;
    for (int i = 0; i < 3; i++) step();
    chk("frz_portA", portA, 32'h21);
    chk("frz_aluop", aluop, 4'h3);
    chk("frz_wsel", wsel_out, 5'd7);
    flush = 1'b1;
    step();
    chk("flush_vld", valid_out, 0);
    chk("flush_op", aluop, 0);
    chk("flush_portA", portA, 0);
    flush = 1'b0; en = 1'b1;
    step();
    chk("lui_portB", portB, 32'h12340000);
    chk("lui_store", store_data, 32'h22);

    // sign/zero immediate and shift source
    alusrc_in = 2'b01; imm16_in = 16'h8001; shift_in = 1'b1; shamt_in = 5'd7;
    step();
    chk("sext_portB", portB, 32'hFFFF8001);
    chk("shamt_portA", portA, 32'd7);
    alusrc_in = 2'b10; shift_in = 1'b0;
    step();
    chk("zext_portB", portB, 32'h00008001);
    chk("noshift_portA", portA, 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
